// File: rtl/wb2uart_pkg.sv
// rtl/wb2uart_pkg.sv - shared types, character constants and hex helper for wb2uart_hex_tx
package wb2uart_pkg;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_STAT  = 2'd2,
        CMD_ABORT = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_S  = 8'h53;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Nibble to ASCII; letters offset so that 10 lands on 'A' or 'a'.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic upper);
        if (nibble < 4'd10)
            return 8'h30 + {4'h0, nibble};
        else
            return (upper ? 8'h37 : 8'h57) + {4'h0, nibble};
    endfunction

    // Frame leader letter; ABORT never reaches the queue, so it maps to 'S' harmlessly.
    function automatic logic [7:0] cmd_char(input cmd_e cmd);
        case (cmd)
            CMD_READ:  return CHAR_R;
            CMD_WRITE: return CHAR_W;
            default:   return CHAR_S;
        endcase
    endfunction

endpackage

// File: rtl/wb2uart_fifo.sv
// rtl/wb2uart_fifo.sv - small synchronous word FIFO with flush
module wb2uart_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb2uart_hex_tx.sv
// rtl/wb2uart_hex_tx.sv - queued command+data words serialised as ASCII hex frames to UartTx
module wb2uart_hex_tx
    import wb2uart_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int EOL_EN     = 1,
    parameter int UPPER      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] in_WB2UART_word,
    input  logic              in_WB2UART_cyc,
    output logic              out_WB2UART_stall,
    output logic              out_busy,
    output logic [7:0]        out_DataByte,
    output logic              out_Start,
    input  logic              in_fComplete
);

    localparam int DIGITS = DATA_W / 4;
    localparam int CNT_W  = $clog2(DIGITS + 2);
    // Characters still to send after the command letter has been loaded.
    localparam logic [CNT_W-1:0] FRAME_REST = CNT_W'(DIGITS + EOL_EN);
    // While rem is above this, the next character is a hex digit rather than the LF.
    localparam logic [CNT_W-1:0] EOL_CNT    = CNT_W'(EOL_EN);

    state_e                    state;
    logic [DATA_W-1:0]         shreg;
    logic [CNT_W-1:0]          rem;
    logic                      fc_q;
    logic                      fc_rise;
    logic [1:0]                cmd_in;
    logic                      abort;
    logic                      push;
    logic                      pop;
    logic [DATA_W+1:0]         fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign cmd_in  = in_WB2UART_word[DATA_W+1:DATA_W];
    assign abort   = in_WB2UART_cyc & (cmd_in == CMD_ABORT);
    assign push    = in_WB2UART_cyc & ~abort & ~fifo_full;
    assign pop     = (state == IDLE) & ~fifo_empty & ~abort;
    assign fc_rise = in_fComplete & ~fc_q;

    assign out_WB2UART_stall = fifo_full;
    assign out_busy          = (fifo_count != '0) | (state != IDLE);

    wb2uart_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .din   (in_WB2UART_word),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Delay register for rising-edge detection of the UartTx completion flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fc_q <= 1'b0;
        else
            fc_q <= in_fComplete;
    end

    // Frame sequencer: command letter, hex digits MSB-first, optional LF, one Start per char.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_Start    <= 1'b0;
            out_DataByte <= 8'h00;
            shreg        <= '0;
            rem          <= '0;
        end else begin
            out_Start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg        <= fifo_dout[DATA_W-1:0];
                        out_DataByte <= cmd_char(cmd_e'(fifo_dout[DATA_W+1:DATA_W]));
                        rem          <= FRAME_REST;
                        state        <= START;
                    end
                end
                START: begin
                    // The Start is committed even on abort, so DRAIN always gets its completion.
                    out_Start <= 1'b1;
                    state     <= abort ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (abort) begin
                        // A completion arriving with the abort means nothing is left in flight.
                        state <= fc_rise ? IDLE : DRAIN;
                    end else if (fc_rise) begin
                        if (rem == '0) begin
                            state <= IDLE;
                        end else begin
                            rem   <= rem - 1'b1;
                            state <= START;
                            if (rem > EOL_CNT) begin
                                out_DataByte <= hex2ascii(shreg[DATA_W-1 -: 4], UPPER != 0);
                                shreg        <= shreg << 4;
                            end else begin
                                out_DataByte <= CHAR_LF;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (fc_rise || abort)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb2uart_hex_tx.sv
// tb/tb_wb2uart_hex_tx.sv - directed self-checking bench for wb2uart_hex_tx
module tb_wb2uart_hex_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] word = '0;
    logic        cyc = 1'b0;
    logic        fc = 1'b0;

    logic        stall_lo, busy_lo, start_lo;
    logic [7:0]  byte_lo;
    logic        stall_up, busy_up, start_up;
    logic [7:0]  byte_up;

    int n_chk = 0;
    int n_pass = 0;

    int fc_timer = 0;
    int fc_hold = 0;
    int hold_len = 1;

    logic [7:0] cap_lo[$];
    logic [7:0] cap_up[$];
    int run = 0;
    int max_run = 0;
    int stab_viol = 0;
    int sync_viol = 0;
    logic [7:0] held_byte = 8'h00;

    always #5 clk = ~clk;

    wb2uart_hex_tx #(.DATA_W(32), .FIFO_DEPTH(4), .EOL_EN(1), .UPPER(0)) u_lo (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_WB2UART_word   (word),
        .in_WB2UART_cyc    (cyc),
        .out_WB2UART_stall (stall_lo),
        .out_busy          (busy_lo),
        .out_DataByte      (byte_lo),
        .out_Start         (start_lo),
        .in_fComplete      (fc)
    );

    wb2uart_hex_tx #(.DATA_W(32), .FIFO_DEPTH(4), .EOL_EN(1), .UPPER(1)) u_up (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_WB2UART_word   (word),
        .in_WB2UART_cyc    (cyc),
        .out_WB2UART_stall (stall_up),
        .out_busy          (busy_up),
        .out_DataByte      (byte_up),
        .out_Start         (start_up),
        .in_fComplete      (fc)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Character monitor plus UartTx stand-in: completion 20 cycles after each Start.
    always @(negedge clk) begin
        if (start_lo) begin
            cap_lo.push_back(byte_lo);
            cap_up.push_back(byte_up);
            held_byte = byte_lo;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (start_lo !== start_up) sync_viol++;
        if (fc_timer > 0 && byte_lo !== held_byte) stab_viol++;
        if (fc_hold > 0) begin
            fc_hold--;
            if (fc_hold == 0) fc = 1'b0;
        end
        if (fc_timer > 0) begin
            fc_timer--;
            if (fc_timer == 0) begin
                fc = 1'b1;
                fc_hold = hold_len;
            end
        end
        if (start_lo) fc_timer = 20;
    end

    function automatic logic [79:0] pack_q(input logic [7:0] q[$], input int base);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            r = {r[71:0], (base + i < q.size()) ? q[base + i] : 8'h00};
        return r;
    endfunction

    function automatic logic [7:0] exp_char(input logic [33:0] w, input int idx, input bit up);
        logic [3:0] nib;
        if (idx == 0) return (w[33:32] == 2'd0) ? 8'h52 : (w[33:32] == 2'd1) ? 8'h57 : 8'h53;
        if (idx == 9) return 8'h0A;
        nib = w[31 - 4 * (idx - 1) -: 4];
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        return (up ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    endfunction

    function automatic logic [79:0] exp_frame(input logic [33:0] w, input bit up);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[71:0], exp_char(w, i, up)};
        return r;
    endfunction

    // Present a word from a negedge; hold it while stalled; return one negedge after acceptance.
    task automatic wr(input logic [1:0] c, input logic [31:0] d, output int waited);
        waited = 0;
        word = {c, d};
        cyc = 1'b1;
        while (stall_lo && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 3000) chk("wr_timeout", 80'(waited), 80'd0);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_lo || fc_timer != 0 || fc) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_in_time"}, 80'(n < 5000), 80'd1);
    endtask

    task automatic wait_starts(input int base, input int cnt, input string tag);
        int n;
        n = 0;
        while (cap_lo.size() - base < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_starts_in_time"}, 80'(n < 2000), 80'd1);
    endtask

    initial begin
        int base;
        int wt;
        logic [33:0] w3 [6];

        repeat (3) @(negedge clk);
        chk("rst_start", 80'(start_lo), 80'd0);
        chk("rst_byte", 80'(byte_lo), 80'h00);
        chk("rst_stall", 80'(stall_lo), 80'd0);
        chk("rst_busy", 80'(busy_lo), 80'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 'W' DEADBEEF, both letter cases, plus first-Start latency
        base = cap_lo.size();
        wr(2'd1, 32'hDEADBEEF, wt);
        cyc = 1'b0;
        @(negedge clk);
        chk("t1_lat_e1", 80'(start_lo), 80'd0);
        @(negedge clk);
        chk("t1_lat_e2", 80'(start_lo), 80'd1);
        wait_idle("t1");
        chk("t1_count", 80'(cap_lo.size() - base), 80'd10);
        chk("t1_lower", pack_q(cap_lo, base), 80'h57_64_65_61_64_62_65_65_66_0A);
        chk("t1_upper", pack_q(cap_up, base), 80'h57_44_45_41_44_42_45_45_46_0A);
        chk("t1_busy_end", 80'(busy_lo), 80'd0);

        // 2: 'R' 0000A5F0, single-cycle Start
        max_run = 0;
        base = cap_lo.size();
        wr(2'd0, 32'h0000A5F0, wt);
        cyc = 1'b0;
        wait_idle("t2");
        chk("t2_count", 80'(cap_lo.size() - base), 80'd10);
        chk("t2_upper", pack_q(cap_up, base), 80'h52_30_30_30_30_41_35_46_30_0A);
        chk("t2_lower", pack_q(cap_lo, base), 80'h52_30_30_30_30_61_35_66_30_0A);
        chk("t2_start_width", 80'(max_run), 80'd1);

        // 3: back-to-back writes fill the FIFO; sixth word held until a slot frees
        w3[0] = {2'd1, 32'h01234567};
        w3[1] = {2'd0, 32'h89ABCDEF};
        w3[2] = {2'd2, 32'hFEDCBA98};
        w3[3] = {2'd1, 32'h76543210};
        w3[4] = {2'd0, 32'h00000000};
        w3[5] = {2'd2, 32'hFFFFFFFF};
        base = cap_lo.size();
        for (int i = 0; i < 6; i++) begin
            wr(w3[i][33:32], w3[i][31:0], wt);
            if (i == 3) chk("t3_not_full_4", 80'(stall_lo), 80'd0);
            if (i == 4) chk("t3_full_5", 80'(stall_lo), 80'd1);
            if (i == 5) chk("t3_sixth_held", 80'(wt > 100), 80'd1);
        end
        cyc = 1'b0;
        wait_idle("t3");
        chk("t3_count", 80'(cap_lo.size() - base), 80'd60);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_frame%0d", i), pack_q(cap_lo, base + 10 * i), exp_frame(w3[i], 1'b0));

        // 4: abort during digit-3 wait with a second word queued
        base = cap_lo.size();
        wr(2'd1, 32'h12345678, wt);
        wr(2'd2, 32'hCAFEF00D, wt);
        cyc = 1'b0;
        wait_starts(base, 4, "t4");
        repeat (3) @(negedge clk);
        word = {2'd3, 32'h0};
        cyc = 1'b1;
        @(negedge clk);
        cyc = 1'b0;
        chk("t4_drain_busy", 80'(busy_lo), 80'd1);
        chk("t4_stall", 80'(stall_lo), 80'd0);
        wait_idle("t4");
        repeat (50) @(negedge clk);
        chk("t4_starts", 80'(cap_lo.size() - base), 80'd4);
        chk("t4_partial", 80'({cap_lo[base], cap_lo[base+1], cap_lo[base+2], cap_lo[base+3]}), 80'h57_31_32_33);
        chk("t4_busy", 80'(busy_lo), 80'd0);
        base = cap_lo.size();
        wr(2'd1, 32'h0F1E2D3C, wt);
        cyc = 1'b0;
        wait_idle("t4b");
        chk("t4_clean_count", 80'(cap_lo.size() - base), 80'd10);
        chk("t4_clean", pack_q(cap_lo, base), 80'h57_30_66_31_65_32_64_33_63_0A);

        // 5: completion held high for five cycles advances only once per char
        hold_len = 5;
        base = cap_lo.size();
        wr(2'd2, 32'h89ABCDEF, wt);
        cyc = 1'b0;
        wait_idle("t5");
        hold_len = 1;
        chk("t5_count", 80'(cap_lo.size() - base), 80'd10);
        chk("t5_frame", pack_q(cap_lo, base), 80'h53_38_39_61_62_63_64_65_66_0A);
        chk("byte_stable", 80'(stab_viol), 80'd0);
        chk("start_sync", 80'(sync_viol), 80'd0);

        // 6: asynchronous reset mid-frame, late completion ignored
        base = cap_lo.size();
        wr(2'd0, 32'h13579BDF, wt);
        cyc = 1'b0;
        wait_starts(base, 3, "t6");
        repeat (5) @(negedge clk);
        chk("t6_byte_before", 80'(byte_lo), 80'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_start", 80'(start_lo), 80'd0);
        chk("t6_rst_byte", 80'(byte_lo), 80'h00);
        chk("t6_rst_busy", 80'(busy_lo), 80'd0);
        chk("t6_rst_stall", 80'(stall_lo), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_no_start", 80'(cap_lo.size() - base), 80'd3);
        chk("t6_busy", 80'(busy_lo), 80'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
